// File: rtl/noc_pkg.sv
// Shared constants and types for the NoC queue reader: flit width,
// header length-field position, framing states and the skid-buffer entry.
package noc_pkg;
  localparam int FLIT_W  = 16;
  localparam int LEN_MSB = 11;
  localparam int LEN_W   = 4;

  typedef enum logic {
    HDR  = 1'b0,
    BODY = 1'b1
  } rd_state_t;

  typedef struct packed {
    logic              last;
    logic [FLIT_W-1:0] data;
  } link_flit_t;
endpackage

// File: rtl/noc_skid_buf.sv
// Two-entry FIFO of {last, data} flits; the head entry is presented
// combinationally so the link sees it in the cycle after capture.
module noc_skid_buf
  import noc_pkg::*;
(
  input  logic       clk,
  input  logic       rst,
  input  logic       push,
  input  link_flit_t push_flit,
  input  logic       pop,
  output link_flit_t head_flit,
  output logic [1:0] count
);
  link_flit_t [1:0] mem_reg;
  logic             wr_ptr_reg;
  logic             rd_ptr_reg;
  logic [1:0]       count_reg;
  logic             do_push;
  logic             do_pop;

  // A pop on an empty buffer is ignored; a push into a full buffer only lands
  // when the head leaves in the same cycle.
  assign do_pop  = pop && (count_reg != 2'd0);
  assign do_push = push && ((count_reg != 2'd2) || do_pop);

  always_ff @(posedge clk) begin
    if (rst) begin
      mem_reg    <= '0;
      wr_ptr_reg <= 1'b0;
      rd_ptr_reg <= 1'b0;
      count_reg  <= 2'd0;
    end else begin
      if (do_push) begin
        mem_reg[wr_ptr_reg] <= push_flit;
        wr_ptr_reg          <= !wr_ptr_reg;
      end
      if (do_pop) begin
        rd_ptr_reg <= !rd_ptr_reg;
      end
      count_reg <= count_reg + {1'b0, do_push} - {1'b0, do_pop};
    end
  end

  assign head_flit = mem_reg[rd_ptr_reg];
  assign count     = count_reg;
endmodule

// File: rtl/noc_queue_reader.sv
// Pop-side drain engine: pops the flit queue, frames packets from the header
// length field and feeds a 2-entry skid buffer. Option: NOC_QUEUE_READER_STATS_EN.
module noc_queue_reader
  import noc_pkg::*;
#(
  parameter int FLIT_W  = noc_pkg::FLIT_W,
  parameter int LEN_MSB = noc_pkg::LEN_MSB
) (
  input  logic              clk,
  input  logic              rst,
  input  logic              q_empty_i,
  output logic              pop_req_o,
  input  logic [FLIT_W-1:0] q_data_i,
  output logic              link_valid_o,
  output logic [FLIT_W-1:0] link_data_o,
  output logic              link_last_o,
  input  logic              link_ready_i,
  output logic              busy_o
`ifdef NOC_QUEUE_READER_STATS_EN
  ,
  output logic [15:0]       pkt_cnt_o,
  output logic [15:0]       flit_cnt_o
`endif
);
  rd_state_t  state_reg, state_next;
  logic [3:0] body_cnt_reg, body_cnt_next;
  logic       inflight_reg;
  logic       cap_last;
  logic [3:0] hdr_len;
  logic       accept;
  logic [1:0] count;
  logic [2:0] occ;
  link_flit_t push_flit;
  link_flit_t head_flit;

  assign hdr_len = q_data_i[LEN_MSB -: 4];
  assign accept  = link_valid_o && link_ready_i;

  // Slots committed after this cycle's accept; a pop is allowed while one remains.
  assign occ       = {1'b0, count} + {2'b00, inflight_reg} - {2'b00, accept};
  assign pop_req_o = !rst && !q_empty_i && (occ < 3'd2);

  always_comb begin
    state_next     = state_reg;
    body_cnt_next  = body_cnt_reg;
    cap_last       = 1'b0;
    push_flit.last = 1'b0;
    push_flit.data = q_data_i;
    if (inflight_reg) begin
      case (state_reg)
        HDR: begin
          body_cnt_next = hdr_len;
          if (hdr_len == 4'd0) begin
            cap_last = 1'b1;
          end else begin
            state_next = BODY;
          end
        end
        BODY: begin
          body_cnt_next = body_cnt_reg - 4'd1;
          if (body_cnt_reg == 4'd1) begin
            cap_last   = 1'b1;
            state_next = HDR;
          end
        end
        default: state_next = HDR;
      endcase
    end
    push_flit.last = cap_last;
  end

  // Reset also drops a pop result still in flight: inflight clears, so the
  // returning data is never captured.
  always_ff @(posedge clk) begin
    if (rst) begin
      state_reg    <= HDR;
      body_cnt_reg <= 4'd0;
      inflight_reg <= 1'b0;
    end else begin
      state_reg    <= state_next;
      body_cnt_reg <= body_cnt_next;
      inflight_reg <= pop_req_o;
    end
  end

  noc_skid_buf u_skid (
    .clk       (clk),
    .rst       (rst),
    .push      (inflight_reg),
    .push_flit (push_flit),
    .pop       (accept),
    .head_flit (head_flit),
    .count     (count)
  );

  assign link_valid_o = (count != 2'd0);
  assign link_data_o  = head_flit.data;
  assign link_last_o  = head_flit.last;
  assign busy_o       = (state_reg == BODY) || inflight_reg || (count != 2'd0);

`ifdef NOC_QUEUE_READER_STATS_EN
  logic [15:0] pkt_cnt_reg;
  logic [15:0] flit_cnt_reg;

  always_ff @(posedge clk) begin
    if (rst) begin
      pkt_cnt_reg  <= 16'd0;
      flit_cnt_reg <= 16'd0;
    end else if (accept) begin
      flit_cnt_reg <= flit_cnt_reg + 16'd1;
      if (link_last_o) begin
        pkt_cnt_reg <= pkt_cnt_reg + 16'd1;
      end
    end
  end

  assign pkt_cnt_o  = pkt_cnt_reg;
  assign flit_cnt_o = flit_cnt_reg;
`endif
endmodule

// File: tb/tb_noc_queue_reader.sv
// Self-checking bench for noc_queue_reader: a cycle table for one packet plus
// directed sequences for framing, backpressure, queue stalls, reset and stats.
module tb_noc_queue_reader;
  logic        clk = 1'b0;
  logic        rst;
  logic        q_empty_i;
  logic        pop_req_o;
  logic [15:0] q_data_i;
  logic        link_valid_o;
  logic [15:0] link_data_o;
  logic        link_last_o;
  logic        link_ready_i;
  logic        busy_o;
`ifdef NOC_QUEUE_READER_STATS_EN
  logic [15:0] pkt_cnt_o;
  logic [15:0] flit_cnt_o;
`endif

  int tests = 0;
  int fails = 0;
  int pops  = 0;
  int q_rd  = 0;
  int q_wr  = 0;
  logic [15:0] qmem [64];
  logic [16:0] rx_q [$];
  logic [16:0] exp_q [$];

  typedef struct {
    logic        rst;
    logic        ready;
    logic        pop;
    logic        valid;
    logic [15:0] data;
    logic        last;
    logic        busy;
    logic        chk_data;
  } vec_t;
  vec_t vecs [8];

  always #5 clk = ~clk;

  noc_queue_reader dut (
    .clk          (clk),
    .rst          (rst),
    .q_empty_i    (q_empty_i),
    .pop_req_o    (pop_req_o),
    .q_data_i     (q_data_i),
    .link_valid_o (link_valid_o),
    .link_data_o  (link_data_o),
    .link_last_o  (link_last_o),
    .link_ready_i (link_ready_i),
    .busy_o       (busy_o)
`ifdef NOC_QUEUE_READER_STATS_EN
    ,
    .pkt_cnt_o    (pkt_cnt_o),
    .flit_cnt_o   (flit_cnt_o)
`endif
  );

  task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
    tests++;
    if (act !== exp) begin
      fails++;
      $display("FAIL %s: got 0x%0h, expected 0x%0h", name, act, exp);
    end
  endtask

  task automatic qpush(input logic [15:0] d);
    qmem[q_wr] = d;
    q_wr++;
    q_empty_i = (q_rd >= q_wr);
  endtask

  // Called in the negedge phase: log pops/accepts, cross posedge, model the
  // queue's one-cycle read latency, return to negedge + 1.
  task automatic tick();
    logic pop_now;
    pop_now = pop_req_o;
    if (pop_now) check("pop_while_empty", 32'(q_empty_i), 32'd0);
    if (link_valid_o && link_ready_i) rx_q.push_back({link_last_o, link_data_o});
    @(posedge clk);
    #1;
    if (pop_now && q_rd < 64) begin
      q_data_i = qmem[q_rd];
      q_rd++;
      pops++;
    end else begin
      q_data_i = 16'hDEAD;
    end
    q_empty_i = (q_rd >= q_wr);
    @(negedge clk);
    #1;
  endtask

  task automatic drain(input int n, input string name);
    int cyc;
    cyc = 0;
    while (!(rx_q.size() >= n && !busy_o) && cyc < 40) begin
      tick();
      cyc++;
    end
    check({name, "_done"}, 32'(cyc < 40), 32'd1);
    check({name, "_count"}, 32'(rx_q.size()), 32'(exp_q.size()));
    for (int i = 0; i < exp_q.size(); i++) begin
      check($sformatf("%s_flit%0d", name, i),
            (i < rx_q.size()) ? 32'(rx_q[i]) : 32'hFFFF_FFFF, 32'(exp_q[i]));
    end
  endtask

  initial begin
    #200000;
    $display("FAIL watchdog: got timeout, expected finish");
    $fatal(1, "watchdog");
  end

  initial begin
    int p0;
    rst = 1'b1; link_ready_i = 1'b1; q_empty_i = 1'b1; q_data_i = 16'h0000;

    //           rst   ready pop   valid data      last  busy  chk_data
    vecs[0] = '{1'b1, 1'b1, 1'b0, 1'b0, 16'h0000, 1'b0, 1'b0, 1'b1};
    vecs[1] = '{1'b0, 1'b1, 1'b1, 1'b0, 16'h0000, 1'b0, 1'b0, 1'b1};
    vecs[2] = '{1'b0, 1'b1, 1'b1, 1'b0, 16'h0000, 1'b0, 1'b1, 1'b1};
    vecs[3] = '{1'b0, 1'b1, 1'b1, 1'b1, 16'h0300, 1'b0, 1'b1, 1'b1};
    vecs[4] = '{1'b0, 1'b1, 1'b1, 1'b1, 16'h0011, 1'b0, 1'b1, 1'b1};
    vecs[5] = '{1'b0, 1'b1, 1'b0, 1'b1, 16'h0022, 1'b0, 1'b1, 1'b1};
    vecs[6] = '{1'b0, 1'b1, 1'b0, 1'b1, 16'h0033, 1'b1, 1'b1, 1'b1};
    vecs[7] = '{1'b0, 1'b1, 1'b0, 1'b0, 16'h0000, 1'b0, 1'b0, 1'b0};

    @(negedge clk);
    #1;
    tick();
    tick();

    // Single L=3 packet, queue loaded while still in reset.
    qpush(16'h0300); qpush(16'h0011); qpush(16'h0022); qpush(16'h0033);
    for (int i = 0; i < 8; i++) begin
      rst = vecs[i].rst;
      link_ready_i = vecs[i].ready;
      #1;
      check($sformatf("t1_v%0d_pop", i),   32'(pop_req_o),    32'(vecs[i].pop));
      check($sformatf("t1_v%0d_valid", i), 32'(link_valid_o), 32'(vecs[i].valid));
      if (vecs[i].chk_data) begin
        check($sformatf("t1_v%0d_data", i), 32'(link_data_o), 32'(vecs[i].data));
        check($sformatf("t1_v%0d_last", i), 32'(link_last_o), 32'(vecs[i].last));
      end
      check($sformatf("t1_v%0d_busy", i),  32'(busy_o),       32'(vecs[i].busy));
      tick();
    end
    $display("[TB] t1 single packet L=3 done");

    // Header-only packet followed by an L=1 packet.
    rx_q.delete();
    qpush(16'h0000); qpush(16'h0100); qpush(16'h0101);
    exp_q = {17'h1_0000, 17'h0_0100, 17'h1_0101};
    #1;
    drain(3, "t2");
    $display("[TB] t2 header-only then L=1 done");

    // Backpressure: ready low for 5 cycles.
    rx_q.delete();
    p0 = pops;
    link_ready_i = 1'b0;
    qpush(16'h0200); qpush(16'h00A1); qpush(16'h00A2);
    #1;
    for (int i = 0; i < 5; i++) begin
      if (link_valid_o) check($sformatf("t3_hold%0d", i), 32'(link_data_o), 32'h0200);
      tick();
    end
    check("t3_pops", 32'(pops - p0), 32'd2);
    check("t3_pop_full", 32'(pop_req_o), 32'd0);
    check("t3_valid", 32'(link_valid_o), 32'd1);
    check("t3_head", 32'(link_data_o), 32'h0200);
    link_ready_i = 1'b1;
    #1;
    exp_q = {17'h0_0200, 17'h0_00A1, 17'h1_00A2};
    drain(3, "t3");
    $display("[TB] t3 backpressure done");

    // Queue runs dry after the header of an L=2 packet.
    rx_q.delete();
    qpush(16'h0200);
    #1;
    tick();
    tick();
    for (int i = 0; i < 4; i++) begin
      check($sformatf("t4_stall_pop%0d", i), 32'(pop_req_o), 32'd0);
      check($sformatf("t4_stall_busy%0d", i), 32'(busy_o), 32'd1);
      tick();
    end
    qpush(16'h00B1); qpush(16'h00B2);
    #1;
    exp_q = {17'h0_0200, 17'h0_00B1, 17'h1_00B2};
    drain(3, "t4");
    $display("[TB] t4 mid-packet stall done");

    // Reset in BODY with body_cnt=5 and a pop in flight.
    qpush(16'h0500);
    #1;
    tick(); tick(); tick();
    check("t5_busy_body", 32'(busy_o), 32'd1);
    qpush(16'h00C1);
    #1;
    check("t5_pop", 32'(pop_req_o), 32'd1);
    tick();
    rst = 1'b1;
    #1;
    tick();
    rst = 1'b0;
    #1;
    check("t5_rst_pop", 32'(pop_req_o), 32'd0);
    check("t5_rst_valid", 32'(link_valid_o), 32'd0);
    check("t5_rst_data", 32'(link_data_o), 32'd0);
    check("t5_rst_last", 32'(link_last_o), 32'd0);
    check("t5_rst_busy", 32'(busy_o), 32'd0);
    rx_q.delete();
    qpush(16'h0000);
    #1;
    exp_q = {17'h1_0000};
    drain(1, "t5");
    $display("[TB] t5 reset mid-packet done");

`ifdef NOC_QUEUE_READER_STATS_EN
    rst = 1'b1;
    #1;
    tick();
    rst = 1'b0;
    rx_q.delete();
    qpush(16'h0000); qpush(16'h0100); qpush(16'h0011);
    qpush(16'h0200); qpush(16'h0021); qpush(16'h0022);
    #1;
    exp_q = {17'h1_0000, 17'h0_0100, 17'h1_0011, 17'h0_0200, 17'h0_0021, 17'h1_0022};
    drain(6, "t6");
    check("t6_pkt_cnt", 32'(pkt_cnt_o), 32'd3);
    check("t6_flit_cnt", 32'(flit_cnt_o), 32'd6);
    $display("[TB] t6 stats counters done");
`endif

    $display("[TB] %0d tests run, %0d failed", tests, fails);
    $finish;
  end
endmodule

// File: doc/noc_queue_reader.md
# noc_queue_reader

- Drain engine on the pop side of a NoC input queue.
- Issues pop requests to the 16-bit flit queue and captures the returned flits, which arrive with one-cycle read latency.
- Buffers flits in a 2-entry output skid buffer and presents them on a valid/ready link toward the crossbar/output port.
- Tracks packet framing from the header length field and marks the last flit of each packet.
- Sustains one flit per cycle when the queue is non-empty and the link is ready.

## Interface
Parameters:
- FLIT_W, 16, flit width; must match the queue data width.
- LEN_MSB, 11, MSB of the 4-bit header length field (field is [LEN_MSB:LEN_MSB-3]).

Ports:
- clk  in  1  system clock; all logic on posedge.
- rst  in  1  reset; synchronous and active-high.
- q_empty_i  in  1  queue holds no flits.
- pop_req_o  out  1  pop request to the queue; one flit per asserted cycle.
- q_data_i  in  FLIT_W  queue read data; valid exactly one cycle after pop_req_o.
- link_valid_o  out  1  flit presented on link_data_o.
- link_data_o  out  FLIT_W  flit to the downstream port.
- link_last_o  out  1  presented flit ends its packet.
- link_ready_i  in  1  downstream accepts the flit this cycle.
- busy_o  out  1  a packet is in progress, or a flit is in flight or buffered.

## Operation
- Flit format:
  - The first flit after reset, or after a last flit, is a header.
  - Header bits [11:8] hold L, the number of body flits (0..15).
- Framing FSM. It advances on each flit captured from the queue, not on link acceptance.
  - HDR: capture header, load body_cnt ← L. If L=0, tag last and stay in HDR; else go to BODY.
  - BODY: each capture decrements body_cnt. The flit with body_cnt==1 is tagged last and returns the FSM to HDR.
- Occupancy:
  - inflight = pop issued last cycle (0/1).
  - count = skid entries held (0..2).
  - Invariant: count + inflight ≤ 2.
- Pop rule: pop_req_o = !rst && !q_empty_i && (count + inflight - (link_valid_o && link_ready_i)) < 2.
  - Pop rule is combinational from registered state and inputs.
- Skid buffer:
  - FIFO of {last, data}. The head drives link_*.
  - link_valid_o = (count != 0).
  - Capture and accept in the same cycle are both honoured.
- The queue must never be popped while empty; the block guarantees this via q_empty_i gating.
- busy_o = (state==BODY) || inflight || (count != 0).

## Timing
- Reset values: pop_req_o=0, link_valid_o=0, link_data_o=0, link_last_o=0, busy_o=0, state=HDR, body_cnt=0, count=0, inflight=0.
- Latency:
  - pop in cycle N → capture at the end of cycle N+1 → link_valid_o high in cycle N+2.
  - Minimum queue-to-link latency is 2 cycles.
- Throughput: 1 flit/cycle sustained with link_ready_i held high.
- link_data_o and link_last_o are stable while link_valid_o && !link_ready_i.
- Full buffer: with count=2 and no accept, pop_req_o=0.
- Accept + capture in the same cycle: count unchanged, head advances.
- Empty buffer: link_valid_o=0, and link_ready_i is ignored.
- q_empty_i asserting mid-packet: pops stall, FSM holds BODY and body_cnt, and framing resumes when the queue refills.
- Reset mid-packet: all state is cleared in the next cycle. An in-flight pop result is discarded, and the next captured flit is treated as a header.
- body_cnt is 4-bit; it never wraps because decrement only occurs in BODY with body_cnt ≥ 1.

## Configuration
- NOC_QUEUE_READER_STATS_EN, when defined, adds:
  - Output pkt_cnt_o [15:0], incremented on each accepted flit with link_last_o=1; wraps at 0xFFFF→0; reset 0.
  - Output flit_cnt_o [15:0], incremented on each accepted flit; wraps likewise; reset 0.
- When undefined, neither counters nor ports exist, and behaviour is otherwise identical.

## Structure
- Shared package noc_pkg holds:
  - FLIT_W and the header field positions.
  - typedef enum {HDR, BODY} rd_state_t.
  - typedef struct {logic last; logic [FLIT_W-1:0] data;} link_flit_t.
- Sub-module noc_skid_buf: 2-entry FIFO of link_flit_t, with push/pop/count, synchronous active-high reset.
- The top level holds the FSM, inflight flag, pop logic and stats.

## Test plan
- Single packet, header 0x0300 (L=3) plus 3 body flits, link_ready_i=1 → 4 flits on the link in consecutive cycles starting 2 cycles after the first pop; link_last_o only on the 4th.
- Header-only packet 0x0000 followed by 0x0100 + 1 body flit → link_last_o on flits 1 and 3.
- link_ready_i=0 for 5 cycles with a non-empty queue → exactly 2 pops, then pop_req_o=0, and link_data_o holds the first flit; releasing ready drains in order with no loss or duplication.
- q_empty_i asserted after the header of an L=2 packet for 4 cycles → busy_o=1 and no pops; on refill, the 2 body flits are output and last is on the second.
- rst pulsed while in BODY with body_cnt=5 → next cycle all outputs 0; the next flit 0x0000 is treated as a header with last=1.
- With NOC_QUEUE_READER_STATS_EN: 3 packets (L=0, 1, 2) fully accepted → pkt_cnt_o=3, flit_cnt_o=6.
